// File: rtl/path_query_sequencer.sv
// Sequences the path-counting listener and network seed port through a list of
// (src, dst) segments and multiplies the per-segment path counts together.
module path_query_sequencer #(
  parameter int NUM_PATHS_DW = 16,
  parameter int PROD_W       = 48,
  parameter int NUM_SEG_MAX  = 4,
  parameter int IDLE_CYC     = 4,
  parameter int TIMEOUT_CYC  = 4096,
  parameter int IDX_W        = (NUM_SEG_MAX > 1) ? $clog2(NUM_SEG_MAX) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cfg_we,
  input  logic [IDX_W-1:0]        i_cfg_idx,
  input  logic [11:0]             i_cfg_src,
  input  logic [11:0]             i_cfg_dst,
  input  logic [IDX_W:0]          i_num_seg,
  input  logic                    i_start,
  output logic                    o_seed_vld,
  output logic [11:0]             o_seed_node,
  input  logic                    i_seed_rdy,
  input  logic                    i_net_idle,
  output logic                    o_lst_rst,
  output logic                    o_set_target_node,
  output logic [11:0]             o_target_node,
  output logic                    o_start_counting,
  input  logic [NUM_PATHS_DW-1:0] i_num_paths,
  input  logic                    i_num_paths_vld,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [PROD_W-1:0]       o_product,
  output logic                    o_overflow,
  output logic                    o_timeout
);

  localparam int SEG_W  = IDX_W + 1;
  localparam int IC_W   = $clog2(IDLE_CYC + 1);
  localparam int TM_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int FULL_W = PROD_W + NUM_PATHS_DW;

  typedef enum logic [3:0] {
    S_IDLE, S_LRST, S_SETTGT, S_SEED0, S_DRAIN, S_SEED1, S_WAITRES, S_ACCUM, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [11:0] src_tbl [NUM_SEG_MAX];
  logic [11:0] dst_tbl [NUM_SEG_MAX];

  logic [SEG_W-1:0]        seg_q, seg_d, num_seg_q, num_seg_d, seg_inc, num_seg_clamp;
  logic [PROD_W-1:0]       product_q, product_d;
  logic                    ovf_q, ovf_d, tmo_q, tmo_d;
  logic [NUM_PATHS_DW-1:0] count_q, count_d;
  logic [IC_W-1:0]         idle_cnt_q, idle_cnt_d;
  logic [TM_W-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic [11:0]             target_q, target_d, seed_node_q, seed_node_d;
  logic                    busy_q, busy_d, done_q, done_d, lst_rst_q, lst_rst_d;
  logic                    set_tgt_q, set_tgt_d, start_cnt_q, start_cnt_d, seed_vld_q, seed_vld_d;
  logic                    res_hit, tmo_hit;
  logic [FULL_W-1:0]       full;
  logic [IDX_W-1:0]        seg_idx;

  assign seg_inc       = seg_q + 1'b1;
  assign seg_idx       = seg_q[IDX_W-1:0];
  assign num_seg_clamp = (i_num_seg > SEG_W'(NUM_SEG_MAX)) ? SEG_W'(NUM_SEG_MAX) : i_num_seg;
  assign res_hit       = i_num_paths_vld & i_net_idle;
  // tmo_cnt_q counts cycles since SEED1 entry, so this fires on the TIMEOUT_CYC-th cycle
  assign tmo_hit       = !res_hit && (tmo_cnt_q >= TM_W'(TIMEOUT_CYC - 1));
  assign full          = {{NUM_PATHS_DW{1'b0}}, product_q} * {{PROD_W{1'b0}}, count_q};

  always_ff @(posedge clk) begin
    if (i_cfg_we && !busy_q && (int'(i_cfg_idx) < NUM_SEG_MAX)) begin
      src_tbl[i_cfg_idx] <= i_cfg_src;
      dst_tbl[i_cfg_idx] <= i_cfg_dst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (i_start) state_d = (i_num_seg == '0) ? S_DONE : S_LRST;
      S_LRST:    state_d = S_SETTGT;
      S_SETTGT:  state_d = S_SEED0;
      S_SEED0:   if (i_seed_rdy) state_d = S_DRAIN;
      S_DRAIN:   if (i_net_idle && (idle_cnt_q == IC_W'(IDLE_CYC - 1))) state_d = S_SEED1;
      S_SEED1:   if (i_seed_rdy) state_d = S_WAITRES;
      S_WAITRES: if (res_hit || tmo_hit) state_d = S_ACCUM;
      S_ACCUM:   state_d = ((seg_inc == num_seg_q) || (count_q == '0)) ? S_DONE : S_LRST;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    seg_d       = seg_q;
    num_seg_d   = num_seg_q;
    product_d   = product_q;
    ovf_d       = ovf_q;
    tmo_d       = tmo_q;
    count_d     = count_q;
    idle_cnt_d  = idle_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    target_d    = target_q;
    seed_node_d = seed_node_q;
    unique case (state_q)
      S_IDLE: if (i_start) begin
        num_seg_d = num_seg_clamp;
        seg_d     = '0;
        product_d = PROD_W'(1);
        ovf_d     = 1'b0;
        tmo_d     = 1'b0;
      end
      S_LRST: begin
        seed_node_d = src_tbl[seg_idx];
        target_d    = dst_tbl[seg_idx];
      end
      S_SEED0:   idle_cnt_d = '0;
      S_DRAIN: begin
        idle_cnt_d = i_net_idle ? idle_cnt_q + 1'b1 : '0;
        tmo_cnt_d  = '0;
      end
      S_SEED1: if (tmo_cnt_q != TM_W'(TIMEOUT_CYC)) tmo_cnt_d = tmo_cnt_q + 1'b1;
      S_WAITRES: begin
        if (tmo_cnt_q != TM_W'(TIMEOUT_CYC)) tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (res_hit) count_d = i_num_paths;
        else if (tmo_hit) begin
          count_d = '0;
          tmo_d   = 1'b1;
        end
      end
      S_ACCUM: begin
        product_d = full[PROD_W-1:0];
        if (|full[FULL_W-1:PROD_W]) ovf_d = 1'b1;
        seg_d = seg_inc;
      end
      default: ;
    endcase
    // strobes are decoded from the next state so they leave a flop aligned with the state
    busy_d      = state_d inside {S_LRST, S_SETTGT, S_SEED0, S_DRAIN, S_SEED1, S_WAITRES, S_ACCUM};
    done_d      = (state_d == S_DONE);
    lst_rst_d   = (state_d == S_LRST);
    set_tgt_d   = (state_d == S_SETTGT);
    start_cnt_d = state_d inside {S_SEED1, S_WAITRES};
    seed_vld_d  = state_d inside {S_SEED0, S_SEED1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q       <= '0;
      num_seg_q   <= '0;
      product_q   <= PROD_W'(1);
      ovf_q       <= 1'b0;
      tmo_q       <= 1'b0;
      count_q     <= '0;
      idle_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      target_q    <= '0;
      seed_node_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lst_rst_q   <= 1'b0;
      set_tgt_q   <= 1'b0;
      start_cnt_q <= 1'b0;
      seed_vld_q  <= 1'b0;
    end else begin
      seg_q       <= seg_d;
      num_seg_q   <= num_seg_d;
      product_q   <= product_d;
      ovf_q       <= ovf_d;
      tmo_q       <= tmo_d;
      count_q     <= count_d;
      idle_cnt_q  <= idle_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      target_q    <= target_d;
      seed_node_q <= seed_node_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      lst_rst_q   <= lst_rst_d;
      set_tgt_q   <= set_tgt_d;
      start_cnt_q <= start_cnt_d;
      seed_vld_q  <= seed_vld_d;
    end
  end

  assign o_seed_vld        = seed_vld_q;
  assign o_seed_node       = seed_node_q;
  assign o_lst_rst         = lst_rst_q;
  assign o_set_target_node = set_tgt_q;
  assign o_target_node     = target_q;
  assign o_start_counting  = start_cnt_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_product         = product_q;
  assign o_overflow        = ovf_q;
  assign o_timeout         = tmo_q;

endmodule

// File: tb/tb_path_query_sequencer.sv
// Self-checking bench for path_query_sequencer: a behavioural network/listener
// environment, a table of directed queries, randomized queries and hand sequences.
module tb_path_query_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cfg_we;
  logic [1:0]  i_cfg_idx;
  logic [11:0] i_cfg_src, i_cfg_dst;
  logic [2:0]  i_num_seg;
  logic        i_start;
  logic        o_seed_vld;
  logic [11:0] o_seed_node;
  logic        i_seed_rdy, i_net_idle;
  logic        o_lst_rst, o_set_target_node, o_start_counting;
  logic [11:0] o_target_node;
  logic [15:0] i_num_paths;
  logic        i_num_paths_vld;
  logic        o_busy, o_done, o_overflow, o_timeout;
  logic [15:0] o_product;

  path_query_sequencer #(.PROD_W(16)) dut (
    .clk(clk), .rst(rst), .i_cfg_we(i_cfg_we), .i_cfg_idx(i_cfg_idx),
    .i_cfg_src(i_cfg_src), .i_cfg_dst(i_cfg_dst), .i_num_seg(i_num_seg),
    .i_start(i_start), .o_seed_vld(o_seed_vld), .o_seed_node(o_seed_node),
    .i_seed_rdy(i_seed_rdy), .i_net_idle(i_net_idle), .o_lst_rst(o_lst_rst),
    .o_set_target_node(o_set_target_node), .o_target_node(o_target_node),
    .o_start_counting(o_start_counting), .i_num_paths(i_num_paths),
    .i_num_paths_vld(i_num_paths_vld), .o_busy(o_busy), .o_done(o_done),
    .o_product(o_product), .o_overflow(o_overflow), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Segment setup shared by the environment and the reference model.
  int       cur_src [4];
  int       cur_dst [4];
  int       cur_cnt [4];
  bit [3:0] cur_novld;
  bit       env_en = 0, bp_mode = 0, glitch_mode = 0;

  int seg_ctr, net_busy, vld_timer, hs_cnt, lrst_cnt, done_cnt;
  bit pend_hs, pend_cnt;

  // Network + listener behaviour: handshakes make the network busy for a few
  // cycles; a counting-phase seed produces a sticky valid count later.
  initial begin
    forever begin
      @(negedge clk);
      if (env_en) begin
        if (pend_hs) begin
          hs_cnt++;
          net_busy = 1 + $urandom % 4;
          if (pend_cnt && seg_ctr >= 0 && seg_ctr < 4 && !cur_novld[seg_ctr])
            vld_timer = net_busy + $urandom % 3;
          pend_hs = 0;
        end
        if (o_lst_rst) begin
          i_num_paths_vld = 0;
          vld_timer = -1;
          lrst_cnt++;
        end
        if (o_set_target_node) begin
          seg_ctr++;
          if (seg_ctr < 4) check("target_node", o_target_node, cur_dst[seg_ctr]);
        end
        if (o_done) done_cnt++;
        if (net_busy > 0) net_busy--;
        i_net_idle = (net_busy == 0) && !(glitch_mode && ($urandom % 6 == 0));
        if (vld_timer > 0) vld_timer--;
        else if (vld_timer == 0) begin
          i_num_paths_vld = 1;
          i_num_paths = cur_cnt[seg_ctr][15:0];
          vld_timer = -1;
        end
        i_seed_rdy = bp_mode ? ($urandom % 3 == 0) : 1'b1;
        if (o_seed_vld && seg_ctr >= 0 && seg_ctr < 4) check("seed_node", o_seed_node, cur_src[seg_ctr]);
        pend_hs  = o_seed_vld && i_seed_rdy;
        pend_cnt = o_start_counting;
      end
    end
  end

  // Reference: product of segment counts, truncated to 16 bits after every step.
  function automatic void model(input int nseg, output longint p, output bit o,
                                output bit tm, output int runs);
    int eff = (nseg > 4) ? 4 : nseg;
    longint c;
    p = 1; o = 0; tm = 0; runs = 0;
    for (int k = 0; k < eff; k++) begin
      c = cur_novld[k] ? 0 : cur_cnt[k];
      if (cur_novld[k]) tm = 1;
      runs++;
      p = p * c;
      if (p >= 65536) o = 1;
      p = p % 65536;
      if (c == 0) break;
    end
  endfunction

  task automatic run_query(input int nseg, input string nm, input bit use_exp,
                           input longint ep, input bit eo, input bit et);
    longint mp; bit mo, mt; int mr; int t;
    model(nseg, mp, mo, mt, mr);
    if (!use_exp) begin ep = mp; eo = mo; et = mt; end
    for (int k = 0; k < 4; k++) begin
      i_cfg_we = 1; i_cfg_idx = k[1:0];
      i_cfg_src = cur_src[k][11:0]; i_cfg_dst = cur_dst[k][11:0];
      @(negedge clk);
    end
    i_cfg_we = 0;
    hs_cnt = 0; lrst_cnt = 0; done_cnt = 0; seg_ctr = -1; net_busy = 0;
    vld_timer = -1; pend_hs = 0; i_num_paths_vld = 0;
    i_num_seg = nseg[2:0]; i_start = 1; env_en = 1;
    @(negedge clk);
    i_start = 0;
    check({nm, "_start_product"}, o_product, 1);
    check({nm, "_start_flags"}, {o_overflow, o_timeout}, 0);
    check({nm, "_start_done"}, o_done, (nseg == 0) ? 1 : 0);
    t = 0;
    while (o_done !== 1'b1 && t < 10000) begin @(negedge clk); t++; end
    check({nm, "_done_in_time"}, (t < 10000) ? 1 : 0, 1);
    check({nm, "_product"}, o_product, ep);
    check({nm, "_overflow"}, o_overflow, eo);
    check({nm, "_timeout"}, o_timeout, et);
    check({nm, "_busy_at_done"}, o_busy, 0);
    repeat (2) @(negedge clk);
    check({nm, "_done_pulses"}, done_cnt, 1);
    check({nm, "_lst_rst_pulses"}, lrst_cnt, mr);
    check({nm, "_handshakes"}, hs_cnt, 2 * mr);
  endtask

  typedef struct {
    int       nseg;
    int       c [4];
    bit [3:0] novld;
    longint   exp_prod;
    bit       exp_ovf;
    bit       exp_tmo;
  } vec_t;

  vec_t vecs [10];

  initial begin
    bit [3:0] pat;
    rst = 1; i_cfg_we = 0; i_cfg_idx = 0; i_cfg_src = 0; i_cfg_dst = 0;
    i_num_seg = 0; i_start = 0; i_seed_rdy = 0; i_net_idle = 0;
    i_num_paths = 0; i_num_paths_vld = 0;
    repeat (3) @(negedge clk);
    check("rst_product", o_product, 1);
    check("rst_outputs", {o_seed_vld, o_lst_rst, o_set_target_node, o_start_counting,
                          o_busy, o_done, o_overflow, o_timeout}, 0);
    check("rst_nodes", {o_seed_node, o_target_node}, 0);
    rst = 0;
    @(negedge clk);

    // Single segment 5->9, write and start in the same cycle, seed backpressure and idle glitch.
    i_cfg_we = 1; i_cfg_idx = 0; i_cfg_src = 5; i_cfg_dst = 9; i_num_seg = 1; i_start = 1;
    @(negedge clk);
    i_cfg_we = 0; i_start = 0;
    check("seq_lrst", {o_lst_rst, o_busy, o_set_target_node}, 3'b110);
    @(negedge clk);
    check("seq_settgt", {o_lst_rst, o_set_target_node, o_seed_vld}, 3'b010);
    check("seq_target", o_target_node, 9);
    @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      check("seq_seed0_hold", {o_seed_vld, o_start_counting, o_set_target_node}, 3'b100);
      check("seq_seed0_node", o_seed_node, 5);
      @(negedge clk);
    end
    i_seed_rdy = 1; i_net_idle = 0;
    @(negedge clk);
    pat = 4'b0;
    for (int j = 0; j < 7; j++) begin
      bit [6:0] idle_pat;
      idle_pat = 7'b1111011;
      i_seed_rdy = 0;
      check("seq_drain", {o_seed_vld, o_start_counting}, 2'b00);
      i_net_idle = idle_pat[j];
      @(negedge clk);
    end
    check("seq_seed1", {o_seed_vld, o_start_counting}, 2'b11);
    check("seq_seed1_node", o_seed_node, 5);
    i_seed_rdy = 1; i_net_idle = 0;
    @(negedge clk);
    i_seed_rdy = 0;
    check("seq_waitres", {o_seed_vld, o_start_counting}, 2'b01);
    i_num_paths = 7; i_num_paths_vld = 1;
    repeat (2) @(negedge clk);
    check("seq_wait_idle", {o_start_counting, o_done}, 2'b10);
    i_net_idle = 1;
    @(negedge clk);
    check("seq_accum", {o_start_counting, o_done, o_busy}, 3'b001);
    @(negedge clk);
    check("seq_done", {o_done, o_busy, o_overflow, o_timeout}, 4'b1000);
    check("seq_product", o_product, 7);
    @(negedge clk);
    check("seq_done_pulse", o_done, 0);
    i_num_paths_vld = 0;

    vecs[0] = '{1, '{7, 0, 0, 0},         4'b0000, 7,     0, 0};
    vecs[1] = '{3, '{3, 5, 11, 0},        4'b0000, 165,   0, 0};
    vecs[2] = '{2, '{300, 300, 0, 0},     4'b0000, 24464, 1, 0};
    vecs[3] = '{1, '{7, 0, 0, 0},         4'b0000, 7,     0, 0};
    vecs[4] = '{3, '{2, 9, 4, 0},         4'b0010, 0,     0, 1};
    vecs[5] = '{0, '{5, 5, 5, 5},         4'b0000, 1,     0, 0};
    vecs[6] = '{5, '{2, 3, 4, 5},         4'b0000, 120,   0, 0};
    vecs[7] = '{4, '{6, 0, 8, 9},         4'b0000, 0,     0, 0};
    vecs[8] = '{3, '{256, 256, 3, 0},     4'b0000, 0,     1, 0};
    vecs[9] = '{4, '{65535, 1, 1, 1},     4'b0000, 65535, 0, 0};
    for (int v = 0; v < 10; v++) begin
      for (int k = 0; k < 4; k++) begin
        cur_src[k] = 100 + 10 * v + k;
        cur_dst[k] = 2000 + 10 * v + k;
        cur_cnt[k] = vecs[v].c[k];
      end
      cur_novld = vecs[v].novld;
      bp_mode = (v % 2 == 1); glitch_mode = (v % 3 == 2);
      run_query(vecs[v].nseg, $sformatf("vec%0d", v), 1,
                vecs[v].exp_prod, vecs[v].exp_ovf, vecs[v].exp_tmo);
    end

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 4; k++) begin
        cur_src[k] = $urandom % 4096;
        cur_dst[k] = $urandom % 4096;
        cur_cnt[k] = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 400);
        cur_novld[k] = ($urandom % 40 == 0);
      end
      bp_mode = $urandom % 2; glitch_mode = $urandom % 2;
      run_query($urandom % 8, $sformatf("rand%0d", r), 0, 0, 0, 0);
    end

    // Asynchronous reset while waiting for the count result.
    cur_novld = 4'b0001; bp_mode = 0; glitch_mode = 0;
    hs_cnt = 0; lrst_cnt = 0; done_cnt = 0; seg_ctr = -1; net_busy = 0;
    vld_timer = -1; pend_hs = 0; i_num_paths_vld = 0;
    i_num_seg = 1; i_start = 1;
    @(negedge clk);
    i_start = 0;
    begin
      int t = 0;
      while (!(o_start_counting && !o_seed_vld) && t < 200) begin @(negedge clk); t++; end
      check("rst_reach_waitres", (t < 200) ? 1 : 0, 1);
    end
    repeat (3) @(negedge clk);
    #1 rst = 1;
    #1;
    check("async_rst_product", o_product, 1);
    check("async_rst_outputs", {o_seed_vld, o_lst_rst, o_set_target_node, o_start_counting,
                                o_busy, o_done, o_overflow, o_timeout}, 0);
    @(negedge clk);
    rst = 0;
    cur_novld = 4'b0000;
    run_query(0, "zero_seg", 1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/path_query_sequencer.md
Name: path_query_sequencer

Overview:
Controller that drives the path-counting listener and the request network's seed port through a multi-segment path query, e.g. svr->dac, dac->fft, fft->out. For each segment it resets the listener and programs the target node. It then runs a calibration pass (arrival counting) and a counting pass, collects the segment path count, and multiplies it into a running product. A host loads up to NUM_SEG_MAX (src, dst) pairs, pulses start, and reads the product when done.

Parameters:
NUM_PATHS_DW, 16, width of per-segment path count from listener
PROD_W, 48, width of accumulated product
NUM_SEG_MAX, 4, depth of segment table (index width = clog2, min 1)
IDLE_CYC, 4, consecutive i_net_idle cycles required to end a drain
TIMEOUT_CYC, 4096, max cycles in count phase before a segment is abandoned

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_cfg_we  in  1  segment table write strobe; ignored while o_busy
i_cfg_idx  in  clog2(NUM_SEG_MAX)  table entry to write
i_cfg_src  in  12  source node of segment
i_cfg_dst  in  12  target node of segment
i_num_seg  in  clog2(NUM_SEG_MAX)+1  segments to run; sampled on start
i_start  in  1  start pulse; honoured only in IDLE
o_seed_vld  out  1  seed request to network
o_seed_node  out  12  node being seeded
i_seed_rdy  in  1  network accepts seed
i_net_idle  in  1  network has no requests in flight
o_lst_rst  out  1  listener synchronous reset
o_set_target_node  out  1  listener target load strobe
o_target_node  out  12  listener target node
o_start_counting  out  1  listener count-phase select
i_num_paths  in  NUM_PATHS_DW  listener path count
i_num_paths_vld  in  1  listener count valid (level, sticky until o_lst_rst)
o_busy  out  1  run in progress
o_done  out  1  one-cycle pulse at end of run
o_product  out  PROD_W  product of segment counts
o_overflow  out  1  sticky: product truncated
o_timeout  out  1  sticky: some segment timed out

Behaviour:
- Reset (async): state IDLE, all outputs 0, o_product = 1, seg index 0, table contents undefined.
- Table writes occur on any clock edge with i_cfg_we=1 and o_busy=0. A write and a start in the same cycle: the write lands first, so the run sees the new entry.
- IDLE, i_start=1: latch i_num_seg, set o_product=1, clear o_overflow/o_timeout, o_busy=1. If i_num_seg=0 go to DONE; else go to LRST. Values i_num_seg > NUM_SEG_MAX clamp to NUM_SEG_MAX.
- LRST (1 cycle): o_lst_rst=1, o_start_counting=0. Next state SETTGT.
- SETTGT (1 cycle): o_set_target_node=1, o_target_node=dst[seg]. o_target_node holds this value until the next SETTGT. Next state SEED0.
- SEED0: o_seed_vld=1, o_seed_node=src[seg], held stable until i_seed_rdy. Handshake is vld&rdy in the same cycle, then go to DRAIN.
- DRAIN: o_start_counting=0. Count consecutive i_net_idle=1 cycles; any 0 clears the count. When count reaches IDLE_CYC, go to SEED1. IDLE_CYC covers the listener's 2-cycle pipeline.
- SEED1: o_start_counting=1 from this state through WAITRES. Seed handshake as in SEED0. Clear the timeout counter on entry. Then go to WAITRES.
- WAITRES: the timeout counter increments every cycle from SEED1 entry.
  - i_num_paths_vld=1 and i_net_idle=1: capture i_num_paths, go to ACCUM.
  - Counter reaches TIMEOUT_CYC first: segment count = 0, o_timeout=1, go to ACCUM. This covers zero arrivals in calibration, where the listener never asserts valid.
- ACCUM (1 cycle): full = o_product * count, computed at PROD_W+NUM_PATHS_DW bits. o_product <= low PROD_W bits; if any upper bit is set, o_overflow=1 (sticky). seg++. If seg == latched num_seg, or count == 0, go to DONE; else go to LRST.
- DONE (1 cycle): o_done=1, o_busy=0 in that cycle. Return to IDLE. o_product/o_overflow/o_timeout hold until the next start.
- i_start while busy: ignored. i_seed_rdy outside SEED0/SEED1: ignored.
- o_start_counting, o_lst_rst and o_set_target_node are registered outputs, glitch-free.
- Reset mid-run: immediate return to IDLE with reset values. o_seed_vld drops asynchronously; the network must tolerate an abandoned seed.

Test Plan:
- 1 segment (src 5 -> dst 9), seed_rdy always 1, idle after 3 cycles, listener returns 7 -> exact state sequence LRST, SETTGT, SEED0, DRAIN (4 idle), SEED1, WAITRES, ACCUM, DONE; o_product=7, o_done single pulse, overflow=0, timeout=0.
- 3 segments returning 3, 5, 11 -> o_product=165; o_lst_rst pulses 3 times; o_target_node follows dst[0..2]; exactly 6 seed handshakes.
- Seed backpressure: i_seed_rdy low 10 cycles in SEED0 -> o_seed_vld/o_seed_node stable throughout; idle glitch (1,1,0,1,1,1,1) in DRAIN -> SEED1 entered only after 4 consecutive 1s.
- No valid in segment 2 of 3 -> after TIMEOUT_CYC, o_timeout=1, o_product=0, DONE without running segment 3.
- PROD_W=16, counts 300 and 300 -> o_product = 90000 mod 65536 = 24464, o_overflow=1; next start clears flags and restores o_product=1.
- Async rst asserted during WAITRES -> all outputs 0 and o_product=1 without a clock edge; i_num_seg=0 start -> o_done next cycle with o_product=1.
